// File: rtl/mem_access_unit.sv
// mem_access_unit
// Load/store sequencer sitting between the MEM-stage control and DataMemory.
// Accepts one word/halfword/byte load or store at a time and drives the
// word-wide, active-low MemRead/MemWrite interface of DataMemory. Sub-word
// stores are performed as read-modify-write. Sub-word loads are extracted
// (big-endian byte order) and sign- or zero-extended. Misaligned requests
// raise Misaligned and never touch memory.
//
// Ports:
//   CLK, RST          clock (rising edge) and asynchronous active-low reset
//   Start             request strobe, only sampled while idle
//   Op                000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, 101 SW, 110 SH, 111 SB
//   Addr              byte address of the request
//   StoreData         store source (SH uses [15:0], SB uses [7:0])
//   Busy              high whenever the sequencer is not idle
//   Done              one-cycle completion pulse
//   LoadData          extended load result, held until the next load completes
//   Misaligned        alignment fault, held until the next accepted request
//   MemAddr           word address to DataMemory
//   MemWData          write data to DataMemory
//   MemRead           active-low read enable to DataMemory
//   MemWrite          active-low write enable (memory writes on falling CLK)
//   MemDataIn         DataMemory read data, combinational from MemAddr

module mem_access_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              Start,
    input  logic [2:0]        Op,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] StoreData,
    output logic              Busy,
    output logic              Done,
    output logic [DATA_W-1:0] LoadData,
    output logic              Misaligned,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [DATA_W-1:0] MemWData,
    output logic              MemRead,
    output logic              MemWrite,
    input  logic [DATA_W-1:0] MemDataIn
);

    localparam logic [2:0] OP_LW  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LHU = 3'b010;
    localparam logic [2:0] OP_LB  = 3'b011;
    localparam logic [2:0] OP_LBU = 3'b100;
    localparam logic [2:0] OP_SW  = 3'b101;
    localparam logic [2:0] OP_SH  = 3'b110;
    localparam logic [2:0] OP_SB  = 3'b111;

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t            state;
    state_t            next_state;
    logic [2:0]        opr;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] sd;
    logic [DATA_W-1:0] merge_word;
    logic              accept;
    logic              req_misaligned;
    logic              opr_is_store;
    logic [7:0]        sel_byte;
    logic [15:0]       sel_half;
    logic [DATA_W-1:0] extracted;
    logic [DATA_W-1:0] merged;

    assign accept       = (state == IDLE) && Start;
    assign opr_is_store = (opr == OP_SW) || (opr == OP_SH) || (opr == OP_SB);

    // Alignment is judged on the incoming request so the fault can be
    // latched in the same edge that accepts it.
    always_comb begin
        req_misaligned = 1'b0;
        case (Op)
            OP_LW, OP_SW:         req_misaligned = (Addr[1:0] != 2'b00);
            OP_LH, OP_LHU, OP_SH: req_misaligned = Addr[0];
            default:              req_misaligned = 1'b0;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (Start) begin
                    if (req_misaligned) begin
                        next_state = DONE;
                    end else if (Op == OP_SW) begin
                        next_state = WRITE;
                    end else begin
                        next_state = READ;
                    end
                end
            end
            READ:    next_state = opr_is_store ? WRITE : DONE;
            WRITE:   next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Memory strobes are registered from next_state so they come straight off
    // flops and cannot glitch; the async reset still releases them at once.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            MemRead  <= 1'b1;
            MemWrite <= 1'b1;
        end else begin
            MemRead  <= (next_state != READ);
            MemWrite <= (next_state != WRITE);
        end
    end

    // Big-endian lane selection: offset 0 is the most significant byte.
    always_comb begin
        sel_byte = MemDataIn[7:0];
        case (a[1:0])
            2'b00:   sel_byte = MemDataIn[31:24];
            2'b01:   sel_byte = MemDataIn[23:16];
            2'b10:   sel_byte = MemDataIn[15:8];
            default: sel_byte = MemDataIn[7:0];
        endcase
        sel_half = a[1] ? MemDataIn[15:0] : MemDataIn[31:16];
    end

    always_comb begin
        extracted = MemDataIn;
        case (opr)
            OP_LH:   extracted = {{16{sel_half[15]}}, sel_half};
            OP_LHU:  extracted = {16'h0000, sel_half};
            OP_LB:   extracted = {{24{sel_byte[7]}}, sel_byte};
            OP_LBU:  extracted = {24'h000000, sel_byte};
            default: extracted = MemDataIn;
        endcase
    end

    // Read-modify-write: replace only the addressed lane with store data.
    always_comb begin
        merged = MemDataIn;
        if (opr == OP_SB) begin
            case (a[1:0])
                2'b00:   merged[31:24] = sd[7:0];
                2'b01:   merged[23:16] = sd[7:0];
                2'b10:   merged[15:8]  = sd[7:0];
                default: merged[7:0]   = sd[7:0];
            endcase
        end else if (opr == OP_SH) begin
            if (a[1]) begin
                merged[15:0] = sd[15:0];
            end else begin
                merged[31:16] = sd[15:0];
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            opr        <= OP_LW;
            a          <= '0;
            sd         <= '0;
            merge_word <= '0;
            LoadData   <= '0;
            Misaligned <= 1'b0;
        end else begin
            if (accept) begin
                opr        <= Op;
                a          <= Addr;
                sd         <= StoreData;
                Misaligned <= req_misaligned;
            end
            if (state == READ) begin
                if (opr_is_store) begin
                    merge_word <= merged;
                end else begin
                    LoadData <= extracted;
                end
            end
        end
    end

    assign Busy     = (state != IDLE);
    assign Done     = (state == DONE);
    assign MemAddr  = {a[ADDR_W-1:2], 2'b00};
    assign MemWData = (opr == OP_SW) ? sd : merge_word;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit
// Self-checking bench for mem_access_unit. A small word memory models
// DataMemory (combinational read, write on falling CLK while MemWrite=0).
// A table of directed requests with hand-computed results is applied in a
// loop, followed by hand-written sequences for busy-time Start pulses, Start
// held high, and reset in the middle of a word store.

module tb_mem_access_unit;

    logic        CLK;
    logic        RST;
    logic        Start;
    logic [2:0]  Op;
    logic [31:0] Addr;
    logic [31:0] StoreData;
    logic        Busy;
    logic        Done;
    logic [31:0] LoadData;
    logic        Misaligned;
    logic [31:0] MemAddr;
    logic [31:0] MemWData;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] MemDataIn;

    logic [31:0] mem [0:15];

    int check_count = 0;
    int error_count = 0;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] sdata;
        int          exp_lat;
        logic [31:0] exp_load;
        logic        exp_mis;
        int          word_idx;
        logic [31:0] exp_word;
        int          exp_rd;
        int          exp_wr;
    } vec_t;

    vec_t vecs [12];

    mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .Start      (Start),
        .Op         (Op),
        .Addr       (Addr),
        .StoreData  (StoreData),
        .Busy       (Busy),
        .Done       (Done),
        .LoadData   (LoadData),
        .Misaligned (Misaligned),
        .MemAddr    (MemAddr),
        .MemWData   (MemWData),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .MemDataIn  (MemDataIn)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    assign MemDataIn = mem[MemAddr[5:2]];

    always @(negedge CLK) begin
        if (!MemWrite) begin
            mem[MemAddr[5:2]] <= MemWData;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Drives one request, waits for Done (bounded), returns the number of
    // rising edges from acceptance to Done and how many sampled cycles had
    // each memory strobe low. Leaves the DUT back in IDLE.
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                                 output int lat, output int rd, output int wr);
        @(negedge CLK);
        Start     = 1'b1;
        Op        = op;
        Addr      = addr;
        StoreData = sdata;
        rd = 0;
        wr = 0;
        @(posedge CLK);
        #1;
        Start = 1'b0;
        lat = 1;
        if (!MemRead)  rd++;
        if (!MemWrite) wr++;
        while (!Done && lat < 10) begin
            @(posedge CLK);
            #1;
            lat++;
            if (!MemRead)  rd++;
            if (!MemWrite) wr++;
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int lat;
        int rd;
        int wr;
        int done_cnt;

        vecs[0]  = '{"SW@8",   3'b101, 32'd8,  32'h12345678, 2, 32'h00000000, 1'b0, 2, 32'h12345678, 0, 1};
        vecs[1]  = '{"LW@8",   3'b000, 32'd8,  32'h0,        2, 32'h12345678, 1'b0, 2, 32'h12345678, 1, 0};
        vecs[2]  = '{"SB@9",   3'b111, 32'd9,  32'h123456AB, 3, 32'h12345678, 1'b0, 2, 32'h12AB5678, 1, 1};
        vecs[3]  = '{"LBU@9",  3'b100, 32'd9,  32'h0,        2, 32'h000000AB, 1'b0, 2, 32'h12AB5678, 1, 0};
        vecs[4]  = '{"LB@9",   3'b011, 32'd9,  32'h0,        2, 32'hFFFFFFAB, 1'b0, 2, 32'h12AB5678, 1, 0};
        vecs[5]  = '{"SH@10",  3'b110, 32'd10, 32'hCDEF8001, 3, 32'hFFFFFFAB, 1'b0, 2, 32'h12AB8001, 1, 1};
        vecs[6]  = '{"LH@10",  3'b001, 32'd10, 32'h0,        2, 32'hFFFF8001, 1'b0, 2, 32'h12AB8001, 1, 0};
        vecs[7]  = '{"LHU@10", 3'b010, 32'd10, 32'h0,        2, 32'h00008001, 1'b0, 2, 32'h12AB8001, 1, 0};
        vecs[8]  = '{"LB@8",   3'b011, 32'd8,  32'h0,        2, 32'h00000012, 1'b0, 2, 32'h12AB8001, 1, 0};
        vecs[9]  = '{"LW@6",   3'b000, 32'd6,  32'h0,        1, 32'h00000012, 1'b1, 2, 32'h12AB8001, 0, 0};
        vecs[10] = '{"SH@5",   3'b110, 32'd5,  32'h00001111, 1, 32'h00000012, 1'b1, 1, 32'h00000000, 0, 0};
        vecs[11] = '{"LW@8b",  3'b000, 32'd8,  32'h0,        2, 32'h12AB8001, 1'b0, 2, 32'h12AB8001, 1, 0};

        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        RST       = 1'b0;
        Start     = 1'b0;
        Op        = 3'b000;
        Addr      = 32'h0;
        StoreData = 32'h0;

        repeat (2) @(posedge CLK);
        #1;
        checkOutput("reset Busy",       {31'b0, Busy},       32'h0);
        checkOutput("reset Done",       {31'b0, Done},       32'h0);
        checkOutput("reset MemRead",    {31'b0, MemRead},    32'h1);
        checkOutput("reset MemWrite",   {31'b0, MemWrite},   32'h1);
        checkOutput("reset LoadData",   LoadData,            32'h0);
        checkOutput("reset MemAddr",    MemAddr,             32'h0);
        checkOutput("reset MemWData",   MemWData,            32'h0);
        checkOutput("reset Misaligned", {31'b0, Misaligned}, 32'h0);
        @(negedge CLK);
        RST = 1'b1;

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].op, vecs[i].addr, vecs[i].sdata, lat, rd, wr);
            checkOutput({vecs[i].name, " latency"},    lat,                 vecs[i].exp_lat);
            checkOutput({vecs[i].name, " LoadData"},   LoadData,            vecs[i].exp_load);
            checkOutput({vecs[i].name, " Misaligned"}, {31'b0, Misaligned}, {31'b0, vecs[i].exp_mis});
            checkOutput({vecs[i].name, " memword"},    mem[vecs[i].word_idx], vecs[i].exp_word);
            checkOutput({vecs[i].name, " rd cycles"},  rd,                  vecs[i].exp_rd);
            checkOutput({vecs[i].name, " wr cycles"},  wr,                  vecs[i].exp_wr);
            checkOutput({vecs[i].name, " idle Busy"},  {31'b0, Busy},       32'h0);
        end

        // Start pulses during a load and through the edge that ends DONE
        // must all be ignored.
        @(negedge CLK);
        Start = 1'b1; Op = 3'b000; Addr = 32'd8; StoreData = 32'h0;
        @(posedge CLK);
        #1;
        Op = 3'b101; StoreData = 32'hFFFFFFFF;
        done_cnt = 0; wr = 0; lat = 0;
        while (!Done && lat < 10) begin
            @(posedge CLK);
            #1;
            lat++;
            if (Done) done_cnt++;
            if (!MemWrite) wr++;
        end
        @(posedge CLK);
        #1;
        Start = 1'b0;
        repeat (4) begin
            @(posedge CLK);
            #1;
            if (Done) done_cnt++;
            if (!MemWrite) wr++;
        end
        checkOutput("busy start Done count", done_cnt, 1);
        checkOutput("busy start wr cycles",  wr,       0);
        checkOutput("busy start memword",    mem[2],   32'h12AB8001);
        checkOutput("busy start LoadData",   LoadData, 32'h12AB8001);

        // Start held high: one access per visit to IDLE, every 3 cycles.
        @(negedge CLK);
        Start = 1'b1; Op = 3'b011; Addr = 32'd11; StoreData = 32'h0;
        done_cnt = 0; rd = 0;
        repeat (9) begin
            @(posedge CLK);
            #1;
            if (Done) done_cnt++;
            if (!MemRead) rd++;
        end
        Start = 1'b0;
        repeat (3) begin
            @(posedge CLK);
            #1;
            if (Done) done_cnt++;
            if (!MemRead) rd++;
        end
        checkOutput("held start Done count", done_cnt, 3);
        checkOutput("held start rd cycles",  rd,       3);
        checkOutput("held start LoadData",   LoadData, 32'h00000001);

        // Reset during WRITE, before the falling edge: no write, no Done.
        @(negedge CLK);
        Start = 1'b1; Op = 3'b101; Addr = 32'd12; StoreData = 32'hDEADBEEF;
        @(posedge CLK);
        #1;
        Start = 1'b0;
        checkOutput("abort in WRITE", {31'b0, MemWrite}, 32'h0);
        RST = 1'b0;
        #1;
        checkOutput("abort Busy",       {31'b0, Busy},       32'h0);
        checkOutput("abort Done",       {31'b0, Done},       32'h0);
        checkOutput("abort MemWrite",   {31'b0, MemWrite},   32'h1);
        checkOutput("abort MemRead",    {31'b0, MemRead},    32'h1);
        checkOutput("abort MemAddr",    MemAddr,             32'h0);
        checkOutput("abort MemWData",   MemWData,            32'h0);
        checkOutput("abort LoadData",   LoadData,            32'h0);
        checkOutput("abort Misaligned", {31'b0, Misaligned}, 32'h0);
        @(negedge CLK);
        #1;
        RST = 1'b1;
        done_cnt = 0;
        repeat (4) begin
            @(posedge CLK);
            #1;
            if (Done) done_cnt++;
        end
        checkOutput("abort memword12", mem[3], 32'h00000000);
        checkOutput("abort no Done",   done_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
